// File: rtl/rob_retire_queue_pkg.sv
// rob_retire_queue_pkg: shared ROB sizing, entry and retire-packet types.
package rob_retire_queue_pkg;
   localparam int ROB_SIZE = 32;
   localparam int PREG_W = 6;
   localparam int AREG_W = 5;
   localparam int WAYS = 3;
   localparam int IDX_W = $clog2(ROB_SIZE);
   localparam int PTR_W = IDX_W + 1;
   typedef struct packed {
      logic              retire_valid;
      logic              is_wb_inst;
      logic [PREG_W-1:0] free_preg;
      logic [AREG_W-1:0] arch_reg;
      logic [PREG_W-1:0] new_preg;
   } rob_out_packet_t;
   typedef struct packed {
      logic              valid;
      logic              complete;
      logic              is_wb;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] new_preg;
      logic [PREG_W-1:0] old_preg;
   } rob_entry_t;
endpackage

// File: rtl/rob_retire_queue_select.sv
// rob_retire_queue_select: in-order retire mask over the 3 oldest ROB entries.
module rob_retire_queue_select
   import rob_retire_queue_pkg::*;
(
   input  logic [PTR_W-1:0]  count,
   input  rob_entry_t [2:0]  window,
   output logic [2:0]        ret_mask,
   output logic [1:0]        ret_cnt
);
   always_comb begin
      ret_mask[0] = window[0].valid && window[0].complete && count > PTR_W'(0);
      ret_mask[1] = ret_mask[0] && window[1].valid && window[1].complete && count > PTR_W'(1);
      ret_mask[2] = ret_mask[1] && window[2].valid && window[2].complete && count > PTR_W'(2);
      ret_cnt = 2'(ret_mask[0]) + 2'(ret_mask[1]) + 2'(ret_mask[2]);
   end
endmodule

// File: rtl/rob_retire_queue.sv
// rob_retire_queue: 3-wide reorder buffer feeding retire/free-preg packets to the freelist.
module rob_retire_queue
   import rob_retire_queue_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic [2:0]             disp_valid,
   input  logic [2:0]             disp_is_wb,
   input  logic [2:0][AREG_W-1:0] disp_areg,
   input  logic [2:0][PREG_W-1:0] disp_new_preg,
   input  logic [2:0][PREG_W-1:0] disp_old_preg,
   output logic [2:0][IDX_W-1:0]  disp_idx,
   output logic [1:0]             slots_avail,
   input  logic [2:0]             cmpl_valid,
   input  logic [2:0][IDX_W-1:0]  cmpl_idx,
   input  logic                   squash,
   input  logic [PTR_W-1:0]       squash_tail,
   output rob_out_packet_t [2:0]  rob_out,
   output logic [PTR_W-1:0]       count_out
);
   rob_entry_t ent_q [ROB_SIZE];
   rob_entry_t ent_d [ROB_SIZE];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count, free_cnt, sq_span;
   rob_entry_t [2:0] win;
   logic [2:0] ret_mask, disp_ok;
   logic [1:0] ret_cnt, disp_cnt;
   assign count = tail_q - head_q;
   assign free_cnt = PTR_W'(ROB_SIZE) - count;
   assign slots_avail = free_cnt > PTR_W'(3) ? 2'd3 : free_cnt[1:0];
   assign count_out = count;
   assign sq_span = tail_q - squash_tail;
   assign disp_ok = squash ? 3'b000 : disp_valid & (slots_avail == 2'd3 ? 3'b111 :
                    slots_avail == 2'd2 ? 3'b011 : slots_avail == 2'd1 ? 3'b001 : 3'b000);
   assign disp_cnt = 2'($countones(disp_ok));
   always_comb begin
      for (int k = 0; k < WAYS; k++) begin
         win[k] = ent_q[head_q[IDX_W-1:0] + IDX_W'(k)];
         disp_idx[k] = tail_q[IDX_W-1:0] + IDX_W'(k);
      end
   end
   rob_retire_queue_select u_select (
      .count    (count),
      .window   (win),
      .ret_mask (ret_mask),
      .ret_cnt  (ret_cnt)
   );
   // non-wb retires carry free_preg=0 so the freelist never reclaims a stale mapping
   always_comb begin
      for (int k = 0; k < WAYS; k++)
         rob_out[k] = ret_mask[k] ? '{retire_valid: 1'b1, is_wb_inst: win[k].is_wb,
                      free_preg: win[k].is_wb ? win[k].old_preg : PREG_W'(0),
                      arch_reg: win[k].areg, new_preg: win[k].new_preg} : '0;
   end
   always_comb begin
      ent_d = ent_q;
      head_d = head_q + PTR_W'(ret_cnt);
      tail_d = squash ? squash_tail : tail_q + PTR_W'(disp_cnt);
      for (int k = 0; k < WAYS; k++)
         if (ret_mask[k]) ent_d[head_q[IDX_W-1:0] + IDX_W'(k)].valid = 1'b0;
      for (int j = 0; j < ROB_SIZE; j++)
         if (squash && {1'b0, IDX_W'(j - int'(squash_tail[IDX_W-1:0]))} < sq_span) ent_d[j].valid = 1'b0;
      for (int i = 0; i < WAYS; i++)
         if (disp_ok[i]) ent_d[disp_idx[i]] = '{valid: 1'b1, complete: 1'b0, is_wb: disp_is_wb[i],
            areg: disp_areg[i], new_preg: disp_new_preg[i], old_preg: disp_old_preg[i]};
      // only entries live before and after this edge accept a completion
      for (int i = 0; i < WAYS; i++)
         if (cmpl_valid[i] && ent_q[cmpl_idx[i]].valid && ent_d[cmpl_idx[i]].valid) ent_d[cmpl_idx[i]].complete = 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         for (int j = 0; j < ROB_SIZE; j++) ent_q[j] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         for (int j = 0; j < ROB_SIZE; j++) ent_q[j] <= ent_d[j];
      end
   end
endmodule
